rect_plotter: RTL and testbench
===============================

RECT_PLOTTER -- requirements
Module: rect_plotter

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, is the number of queued draw commands; it SHALL be a power of two and at least 2.
REQ-002 Parameter SCREEN_W, default 160, is the visible width in pixels.
REQ-003 Parameter SCREEN_H, default 120, is the visible height in pixels.
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset, named as below.
REQ-005 clock  in  1  system clock, 50 MHz.
REQ-006 resetn  in  1  asynchronous active-low reset.
REQ-007 cmd_valid  in  1  a draw command is presented.
REQ-008 cmd_ready  out  1  a command is accepted on this edge when cmd_valid is also high.
REQ-009 cmd_x, cmd_y  in  8 each  top-left corner of the rectangle.
REQ-010 cmd_w, cmd_h  in  8 each  rectangle width and height in pixels.
REQ-011 cmd_colour  in  3  RGB fill colour.
REQ-012 x  out  8  pixel column sent to vga_adapter.
REQ-013 y  out  7  pixel row sent to vga_adapter.
REQ-014 colour  out  3  pixel colour sent to vga_adapter.
REQ-015 plot  out  1  the pixel on x, y and colour is written this cycle.
REQ-016 busy  out  1  the FIFO is non-empty or the engine is not IDLE.
REQ-017 done  out  1  one-cycle pulse after the last pixel of a command.

Function
REQ-018 cmd_ready SHALL equal not-full; a push while full is refused, even if a pop happens on the same edge.
REQ-019 The FIFO SHALL capture {x, y, w, h, colour} on the edge where cmd_valid and cmd_ready are both high; commands are drawn in order.
REQ-020 The state machine SHALL have three states: IDLE, LOAD and DRAW.
REQ-021 IDLE -> LOAD when the FIFO is non-empty; LOAD pops one entry into the working registers and clears the counters dx and dy.
REQ-022 LOAD -> IDLE with a done pulse when w == 0 or h == 0; otherwise LOAD -> DRAW.
REQ-023 In DRAW the block SHALL emit one pixel per cycle, row-major: dx counts 0..w-1, and on wrap dy increments.
REQ-024 Pixel outputs SHALL be registered: x = cmd_x + dx and y = cmd_y + dy, with colour equal to the command colour.
REQ-025 Sums SHALL be computed 9 bits wide; plot SHALL be 0 when the 9-bit x is at least SCREEN_W or the 9-bit y is at least SCREEN_H (clipped pixel, traversal continues).
REQ-026 After the pixel at dx = w-1, dy = h-1, the state SHALL go to IDLE and done SHALL pulse on the following cycle.
REQ-027 A command accepted at edge k SHALL show its first pixel on the outputs after edge k+3 when the engine was IDLE with an empty FIFO; the command occupies exactly w*h DRAW cycles.
REQ-028 Back-to-back commands SHALL have a gap of 2 cycles (IDLE, LOAD) between the last pixel of one and the first pixel of the next.
REQ-029 Outside DRAW, plot SHALL be 0; x, y and colour hold their last values.
REQ-030 The geometry of a queued command SHALL NOT change after acceptance; changes on the cmd_* inputs affect only later pushes.

Reset
REQ-031 While resetn is low: FIFO empty, state IDLE, plot 0, done 0, busy 0, x, y and colour 0, cmd_ready 1.
REQ-032 Reset asserted mid-DRAW or with the FIFO occupied SHALL discard all pending work immediately, with no further plot pulses.

Structure
REQ-033 A shared package battle_pkg SHALL hold SCREEN_W, SCREEN_H, the colour constants (BLACK = 3'b000, WHITE = 3'b111, RED = 3'b100, BLUE = 3'b001, GREEN = 3'b010) and the rect_plotter state encoding.
REQ-034 The FIFO SHALL be a sub-module named cmd_fifo: synchronous, a single clock, the same reset, and full/empty flags.

Verification
REQ-035 Push (5,110,16,2,WHITE) from idle: first plot after edge k+3, then 32 plots with x = 5..20 and y = 110..111, then done; busy drops.
REQ-036 Push (150,115,16,10,RED): 160 DRAW cycles; plot is 1 only for x 150..159 and y 115..119 (50 pixels).
REQ-037 Push 5 commands with the engine stalled (FIFO_DEPTH = 4): cmd_ready goes low after 4; the 5th is accepted only after the first pop, and drawing order is preserved.
REQ-038 Push (10,10,0,5,BLUE): no plot pulse, done pulses 2 cycles after the pop cycle.
REQ-039 Assert resetn low mid-way through the pixels of (0,0,160,120,BLACK) with 2 commands queued: plot is 0 at once, and after release busy is 0 and cmd_ready is 1.
REQ-040 Push two 1x1 commands back to back: the pixels are 3 cycles apart (gap of 2), with two done pulses.

Source files
------------

// File: rtl/battle_pkg.sv
// Shared screen geometry, palette and rect_plotter types used across the drawing blocks.
package battle_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    localparam logic [2:0] BLACK = 3'b000;
    localparam logic [2:0] WHITE = 3'b111;
    localparam logic [2:0] RED   = 3'b100;
    localparam logic [2:0] BLUE  = 3'b001;
    localparam logic [2:0] GREEN = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DRAW = 2'd2
    } plot_state_t;

    typedef struct packed {
        logic [7:0] x;
        logic [7:0] y;
        logic [7:0] w;
        logic [7:0] h;
        logic [2:0] colour;
    } rect_cmd_t;

    localparam int CMD_W = $bits(rect_cmd_t);

endpackage

// File: rtl/cmd_fifo.sv
// Single-clock command FIFO with full/empty flags; pushes while full and pops while empty are ignored.
module cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 35
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic             do_push;
    logic             do_pop;

    // Extra pointer bit separates the full and empty cases when the indices match.
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign empty   = (wptr == rptr);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rptr[AW-1:0]];

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/rect_plotter.sv
// Rectangle fill engine: queues draw commands and streams one clipped pixel per cycle to vga_adapter.
//   state | meaning
//   IDLE  | waiting for a queued command
//   LOAD  | pop head command into working registers, clear dx/dy
//   DRAW  | one pixel per cycle, row-major over the rectangle
module rect_plotter #(
    parameter int FIFO_DEPTH = 4,
    parameter int SCREEN_W   = battle_pkg::SCREEN_W,
    parameter int SCREEN_H   = battle_pkg::SCREEN_H
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_x,
    input  logic [7:0] cmd_y,
    input  logic [7:0] cmd_w,
    input  logic [7:0] cmd_h,
    input  logic [2:0] cmd_colour,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       busy,
    output logic       done
);

    import battle_pkg::*;

    localparam logic [8:0] X_LIMIT = 9'(SCREEN_W);
    localparam logic [8:0] Y_LIMIT = 9'(SCREEN_H);

    rect_cmd_t   push_cmd;
    rect_cmd_t   head_cmd;
    rect_cmd_t   work;
    logic        fifo_full;
    logic        fifo_empty;
    logic        fifo_pop;
    plot_state_t state;
    plot_state_t state_nxt;
    logic [7:0]  dx;
    logic [7:0]  dy;
    logic [8:0]  sum_x;
    logic [8:0]  sum_y;
    logic        row_end;
    logic        last_pixel;
    logic        finish;
    logic        finish_q;

    assign push_cmd = {cmd_x, cmd_y, cmd_w, cmd_h, cmd_colour};

    cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (CMD_W)
    ) u_cmd_fifo (
        .clock  (clock),
        .resetn (resetn),
        .push   (cmd_valid),
        .pop    (fifo_pop),
        .wdata  (push_cmd),
        .rdata  (head_cmd),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    assign cmd_ready  = !fifo_full;
    assign busy       = !fifo_empty || (state != ST_IDLE);
    assign row_end    = (dx == work.w - 8'd1);
    assign last_pixel = row_end && (dy == work.h - 8'd1);
    assign sum_x      = {1'b0, work.x} + {1'b0, dx};
    assign sum_y      = {1'b0, work.y} + {1'b0, dy};

    always_comb begin
        state_nxt = state;
        fifo_pop  = 1'b0;
        finish    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                fifo_pop = 1'b1;
                if (head_cmd.w == 8'd0 || head_cmd.h == 8'd0) begin
                    state_nxt = ST_IDLE;
                    finish    = 1'b1;
                end else begin
                    state_nxt = ST_DRAW;
                end
            end
            ST_DRAW: begin
                if (last_pixel) begin
                    state_nxt = ST_IDLE;
                    finish    = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) state <= ST_IDLE;
        else         state <= state_nxt;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            work <= '0;
            dx   <= '0;
            dy   <= '0;
        end else if (state == ST_LOAD) begin
            work <= head_cmd;
            dx   <= '0;
            dy   <= '0;
        end else if (state == ST_DRAW) begin
            if (row_end) begin
                dx <= '0;
                dy <= dy + 8'd1;
            end else begin
                dx <= dx + 8'd1;
            end
        end
    end

    // Pixel stage is one register deep, so done trails finish by two edges to land after the last pixel.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            x        <= '0;
            y        <= '0;
            colour   <= '0;
            plot     <= 1'b0;
            finish_q <= 1'b0;
            done     <= 1'b0;
        end else begin
            finish_q <= finish;
            done     <= finish_q;
            plot     <= 1'b0;
            if (state == ST_DRAW) begin
                x      <= sum_x[7:0];
                y      <= sum_y[6:0];
                colour <= work.colour;
                plot   <= (sum_x < X_LIMIT) && (sum_y < Y_LIMIT);
            end
        end
    end

endmodule

// File: tb/tb_rect_plotter.sv
// Directed bench for rect_plotter: expected visible pixels are queued at push time and popped on each plot.
module tb_rect_plotter;

    import battle_pkg::*;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [7:0] cmd_x = '0;
    logic [7:0] cmd_y = '0;
    logic [7:0] cmd_w = '0;
    logic [7:0] cmd_h = '0;
    logic [2:0] cmd_colour = '0;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;
    logic       busy;
    logic       done;

    int          n_checks = 0;
    int          n_fail = 0;
    int          edge_n = 0;
    logic [17:0] sb[$];
    int          plot_edges[$];
    int          done_edges[$];

    rect_plotter #(
        .FIFO_DEPTH (4),
        .SCREEN_W   (160),
        .SCREEN_H   (120)
    ) dut (
        .clock      (clock),
        .resetn     (resetn),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_x      (cmd_x),
        .cmd_y      (cmd_y),
        .cmd_w      (cmd_w),
        .cmd_h      (cmd_h),
        .cmd_colour (cmd_colour),
        .x          (x),
        .y          (y),
        .colour     (colour),
        .plot       (plot),
        .busy       (busy),
        .done       (done)
    );

    always #10 clock = ~clock;

    always @(posedge clock) edge_n <= edge_n + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: every plotted pixel must match the oldest outstanding expected pixel.
    always @(negedge clock) begin
        if (resetn === 1'b1) begin
            if (plot === 1'b1) begin
                plot_edges.push_back(edge_n);
                if (sb.size() == 0) chk("plot_with_nothing_expected", {31'd0, plot}, 32'd0);
                else                chk("pixel_xyc", {14'd0, x, y, colour}, {14'd0, sb.pop_front()});
            end
            if (done === 1'b1) done_edges.push_back(edge_n);
        end
    end

    task automatic push(input logic [7:0] px, input logic [7:0] py, input logic [7:0] pw,
                        input logic [7:0] ph, input logic [2:0] pc, output int k);
        int guard = 0;
        cmd_valid  = 1'b1;
        cmd_x      = px;
        cmd_y      = py;
        cmd_w      = pw;
        cmd_h      = ph;
        cmd_colour = pc;
        while (cmd_ready !== 1'b1 && guard < 1000) begin
            @(negedge clock);
            guard++;
        end
        if (guard >= 1000) chk("push_ready_timeout", {31'd0, cmd_ready}, 32'd1);
        @(posedge clock);
        @(negedge clock);
        k = edge_n;
        cmd_valid  = 1'b0;
        cmd_x      = 8'hA5;
        cmd_y      = 8'h5A;
        cmd_w      = 8'h33;
        cmd_h      = 8'h44;
        cmd_colour = 3'b011;
        for (int j = 0; j < ph; j++) begin
            for (int i = 0; i < pw; i++) begin
                int sx;
                int sy;
                sx = px + i;
                sy = py + j;
                if (sx < 160 && sy < 120) sb.push_back({sx[7:0], sy[6:0], pc});
            end
        end
    endtask

    task automatic wait_done(input int n);
        int guard = 0;
        while (done_edges.size() < n && guard < 30000) begin
            @(negedge clock);
            guard++;
        end
        chk("done_pulse_count", done_edges.size(), n);
    endtask

    task automatic clear_logs();
        plot_edges.delete();
        done_edges.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int k2;
        int kf;
        int nd;
        int np;

        repeat (3) @(negedge clock);
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_plot", {31'd0, plot}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_x", {24'd0, x}, 32'd0);
        chk("rst_y", {25'd0, y}, 32'd0);
        chk("rst_colour", {29'd0, colour}, 32'd0);
        resetn = 1'b1;
        @(negedge clock);

        // 16x2 white rectangle from idle
        clear_logs();
        push(8'd5, 8'd110, 8'd16, 8'd2, WHITE, k);
        chk("t1_busy_after_push", {31'd0, busy}, 32'd1);
        wait_done(1);
        chk("t1_first_plot_edge", plot_edges.size() > 0 ? plot_edges[0] : -1, k + 3);
        chk("t1_plot_count", plot_edges.size(), 32);
        chk("t1_last_plot_edge", plot_edges.size() > 0 ? plot_edges[$] : -1, k + 34);
        chk("t1_done_edge", done_edges.size() > 0 ? done_edges[0] : -1, k + 35);
        chk("t1_busy_dropped", {31'd0, busy}, 32'd0);
        chk("t1_sb_drained", sb.size(), 0);
        @(negedge clock);
        chk("t1_done_one_cycle", {31'd0, done}, 32'd0);

        // clipped at the bottom-right corner
        clear_logs();
        push(8'd150, 8'd115, 8'd16, 8'd10, RED, k);
        wait_done(1);
        chk("t2_plot_count", plot_edges.size(), 50);
        chk("t2_first_plot_edge", plot_edges.size() > 0 ? plot_edges[0] : -1, k + 3);
        chk("t2_last_plot_edge", plot_edges.size() > 0 ? plot_edges[$] : -1, k + 76);
        chk("t2_done_edge", done_edges.size() > 0 ? done_edges[0] : -1, k + 163);
        chk("t2_sb_drained", sb.size(), 0);

        // zero-width command
        clear_logs();
        push(8'd10, 8'd10, 8'd0, 8'd5, BLUE, k);
        wait_done(1);
        chk("t3_no_plot", plot_edges.size(), 0);
        chk("t3_done_edge", done_edges.size() > 0 ? done_edges[0] : -1, k + 3);

        // two 1x1 commands back to back
        clear_logs();
        push(8'd1, 8'd2, 8'd1, 8'd1, GREEN, k);
        push(8'd3, 8'd4, 8'd1, 8'd1, RED, k2);
        chk("t4_back_to_back_accept", k2, k + 1);
        wait_done(2);
        chk("t4_first_plot_edge", plot_edges.size() > 0 ? plot_edges[0] : -1, k + 3);
        chk("t4_pixel_spacing", plot_edges.size() > 1 ? plot_edges[1] - plot_edges[0] : -1, 3);
        chk("t4_first_done_edge", done_edges.size() > 0 ? done_edges[0] : -1, k + 4);
        chk("t4_done_spacing", done_edges.size() > 1 ? done_edges[1] - done_edges[0] : -1, 3);

        // fill the FIFO while a long rectangle is drawing
        clear_logs();
        push(8'd0, 8'd0, 8'd20, 8'd2, GREEN, k);
        repeat (3) @(negedge clock);
        push(8'd30, 8'd30, 8'd1, 8'd1, RED, k2);
        push(8'd31, 8'd30, 8'd1, 8'd1, BLUE, k2);
        push(8'd32, 8'd30, 8'd1, 8'd1, WHITE, k2);
        chk("t5_ready_with_3_queued", {31'd0, cmd_ready}, 32'd1);
        push(8'd33, 8'd30, 8'd1, 8'd1, BLACK, k2);
        chk("t5_ready_low_when_full", {31'd0, cmd_ready}, 32'd0);
        push(8'd34, 8'd30, 8'd1, 8'd1, GREEN, kf);
        chk("t5_fifth_accept_edge", kf, k + 45);
        wait_done(6);
        chk("t5_plot_count", plot_edges.size(), 45);
        chk("t5_sb_drained", sb.size(), 0);

        // reset in the middle of a full-screen fill with two commands queued
        clear_logs();
        push(8'd0, 8'd0, 8'd160, 8'd120, BLACK, k);
        push(8'd1, 8'd1, 8'd1, 8'd1, RED, k2);
        push(8'd2, 8'd2, 8'd1, 8'd1, RED, k2);
        repeat (100) @(negedge clock);
        chk("t6_plot_before_reset", {31'd0, plot}, 32'd1);
        resetn = 1'b0;
        #1;
        chk("t6_plot_cleared_at_once", {31'd0, plot}, 32'd0);
        chk("t6_busy_in_reset", {31'd0, busy}, 32'd0);
        chk("t6_ready_in_reset", {31'd0, cmd_ready}, 32'd1);
        sb.delete();
        nd = done_edges.size();
        np = plot_edges.size();
        repeat (2) @(negedge clock);
        resetn = 1'b1;
        repeat (20) @(negedge clock);
        chk("t6_busy_after_release", {31'd0, busy}, 32'd0);
        chk("t6_ready_after_release", {31'd0, cmd_ready}, 32'd1);
        chk("t6_no_done_after_release", done_edges.size(), nd);
        chk("t6_no_plot_after_release", plot_edges.size(), np);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
